ntt_basemul: RTL and testbench

Streaming NTT-domain base-case multiplier, directly downstream of `ntt`. It consumes forward-NTT coefficient pairs (â[2i], â[2i+1]) in the same pair/index format `ntt` emits. Each pair is multiplied by a stored second operand pair (b̂[2i], b̂[2i+1]) modulo (X² − γᵢ), with γᵢ = 17^(2·br7(i)+1) mod 3329. Fully reduced product pairs are emitted at one pair per clock for the following inverse NTT or accumulator.

---
 rtl/ntt_basemul.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_basemul.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ntt_basemul.sv
// Kyber NTT-domain base-case multiplier: (a0 + a1 X)(b0 + b1 X) mod (X^2 - gamma_i), one pair per clock.
// Input capture then four arithmetic stages (sampled at edge k -> valid after edge k+4); no stall input.
module ntt_basemul #(
  parameter int DEPTH = 8,
  parameter int Q     = 3329
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             load_b,
  input  logic             readin,
  input  logic [15:0]      din_1,
  input  logic [15:0]      din_2,
  input  logic [DEPTH-1:0] in_index,
  output logic [15:0]      dout_1,
  output logic [15:0]      dout_2,
  output logic [DEPTH-1:0] out_index,
  output logic             dout_valid,
  output logic             done
);
  localparam int          NP        = 1 << (DEPTH - 1);
  localparam int          PW        = DEPTH - 1;
  localparam logic [24:0] BARRETT_M = 25'd20642678;  // floor(2^36 / 3329)
  localparam logic [25:0] Q26       = 26'(Q);

  function automatic logic [NP*12-1:0] gen_gamma();
    logic [256*12-1:0] pw;
    logic [NP*12-1:0]  g;
    int unsigned       x;
    int                r;
    pw = '0;
    g  = '0;
    x  = 1;
    for (int k = 0; k < 256; k++) begin
      pw[k*12 +: 12] = x[11:0];
      x = (x * 17) % Q;
    end
    for (int i = 0; i < NP; i++) begin
      r = 0;
      for (int b = 0; b < PW; b++) r = r | (((i >> b) & 1) << (PW - 1 - b));
      g[i*12 +: 12] = pw[(2*r+1)*12 +: 12];
    end
    return g;
  endfunction

  localparam logic [NP*12-1:0] GAMMA = gen_gamma();

  // Barrett estimate is at most one short, so a single conditional subtract fully reduces.
  function automatic logic [11:0] mod_q(input logic [24:0] x);
    logic [49:0] prod;
    logic [13:0] qe;
    logic [25:0] r;
    prod = {25'd0, x} * {25'd0, BARRETT_M};
    qe   = 14'(prod >> 36);
    r    = {1'b0, x} - ({12'd0, qe} * Q26);
    if (r >= Q26) r = r - Q26;
    return 12'(r);
  endfunction

  function automatic logic [23:0] mul12(input logic [11:0] a, input logic [11:0] b);
    return {12'd0, a} * {12'd0, b};
  endfunction

  typedef struct packed {
    logic [11:0]   a0, a1, b0, b1, g;
    logic [PW-1:0] idx;
  } st0_t;
  typedef struct packed {
    logic [23:0]   p00, p01, p10, p11;
    logic [11:0]   g;
    logic [PW-1:0] idx;
  } st1_t;
  typedef struct packed {
    logic [23:0]   p00;
    logic [11:0]   t, g;
    logic [24:0]   s1;
    logic [PW-1:0] idx;
  } st2_t;
  typedef struct packed {
    logic [24:0]   s0, s1;
    logic [PW-1:0] idx;
  } st3_t;

  logic [11:0]   bmem0_q [NP];
  logic [11:0]   bmem1_q [NP];
  logic [PW-1:0] pair_idx;
  logic          unused_bits;

  st0_t          st0_d, st0_q;
  st1_t          st1_d, st1_q;
  st2_t          st2_d, st2_q;
  st3_t          st3_d, st3_q;
  logic [3:0]    vld_d, vld_q;
  logic [11:0]   c0_d, c0_q, c1_d, c1_q;
  logic [PW-1:0] oidx_d, oidx_q;
  logic          ovld_d, ovld_q;
  logic [PW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;

  assign pair_idx    = in_index[DEPTH-1:1];
  assign unused_bits = ^{din_1[15:12], din_2[15:12], in_index[0]};

  always_ff @(posedge clk) begin
    if (readin && load_b) begin
      bmem0_q[pair_idx] <= din_2[11:0];
      bmem1_q[pair_idx] <= din_1[11:0];
    end
  end

  // Stage data only advances with its valid, so idle outputs hold the last result.
  always_comb begin
    st0_d  = st0_q;
    st1_d  = st1_q;
    st2_d  = st2_q;
    st3_d  = st3_q;
    c0_d   = c0_q;
    c1_d   = c1_q;
    oidx_d = oidx_q;
    vld_d  = {vld_q[2:0], readin & ~load_b};
    ovld_d = vld_q[3];
    if (vld_d[0]) begin
      st0_d.a0  = din_2[11:0];
      st0_d.a1  = din_1[11:0];
      st0_d.b0  = bmem0_q[pair_idx];
      st0_d.b1  = bmem1_q[pair_idx];
      st0_d.g   = GAMMA[pair_idx*12 +: 12];
      st0_d.idx = pair_idx;
    end
    if (vld_q[0]) begin
      st1_d.p00 = mul12(st0_q.a0, st0_q.b0);
      st1_d.p01 = mul12(st0_q.a0, st0_q.b1);
      st1_d.p10 = mul12(st0_q.a1, st0_q.b0);
      st1_d.p11 = mul12(st0_q.a1, st0_q.b1);
      st1_d.g   = st0_q.g;
      st1_d.idx = st0_q.idx;
    end
    if (vld_q[1]) begin
      st2_d.p00 = st1_q.p00;
      st2_d.t   = mod_q({1'b0, st1_q.p11});
      st2_d.g   = st1_q.g;
      st2_d.s1  = {1'b0, st1_q.p01} + {1'b0, st1_q.p10};
      st2_d.idx = st1_q.idx;
    end
    if (vld_q[2]) begin
      st3_d.s0  = {1'b0, st2_q.p00} + {1'b0, mul12(st2_q.t, st2_q.g)};
      st3_d.s1  = st2_q.s1;
      st3_d.idx = st2_q.idx;
    end
    if (vld_q[3]) begin
      c0_d   = mod_q(st3_q.s0);
      c1_d   = mod_q(st3_q.s1);
      oidx_d = st3_q.idx;
    end
  end

  // A pair landing on the same edge as set belongs to the new pass.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (set) begin
      cnt_d  = PW'(vld_q[3]);
      done_d = 1'b0;
    end else if (vld_q[3]) begin
      if (cnt_q == PW'(NP - 1)) done_d = 1'b1;
      else                      cnt_d  = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st0_q  <= '0;
      st1_q  <= '0;
      st2_q  <= '0;
      st3_q  <= '0;
      vld_q  <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      oidx_q <= '0;
      ovld_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      st2_q  <= st2_d;
      st3_q  <= st3_d;
      vld_q  <= vld_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
      oidx_q <= oidx_d;
      ovld_q <= ovld_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign dout_2     = {4'd0, c0_q};
  assign dout_1     = {4'd0, c1_q};
  assign out_index  = {oidx_q, 1'b0};
  assign dout_valid = ovld_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ntt_basemul.sv
// Directed/streamed bench for ntt_basemul with a cycle-stamped scoreboard and immediate assertions.
module tb_ntt_basemul;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        reset, set, load_b, readin;
  logic [15:0] din_1, din_2, dout_1, dout_2;
  logic [7:0]  in_index, out_index;
  logic        dout_valid, done;

  ntt_basemul #(.DEPTH(8), .Q(3329)) dut (
    .clk(clk), .reset(reset), .set(set), .load_b(load_b), .readin(readin),
    .din_1(din_1), .din_2(din_2), .in_index(in_index),
    .dout_1(dout_1), .dout_2(dout_2), .out_index(out_index),
    .dout_valid(dout_valid), .done(done)
  );

  typedef struct { int c0; int c1; int idx; int t; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0, pass_cnt = 0;
  int   last_c0 = 0, last_c1 = 0, last_idx = 0;
  int   bm0 [128];
  int   bm1 [128];
  logic set_q = 1'b0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    set_q <= set;
  end

  function automatic int gamma(input int i);
    int r = 0, x = 1;
    for (int b = 0; b < 7; b++) if (i[b]) r = r | (1 << (6 - b));
    for (int k = 0; k < 2*r + 1; k++) x = (x * 17) % Q;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driven just after an edge; sampled at the next edge, result expected five counts later.
  task automatic send(input logic ld, input logic [15:0] d2, input logic [15:0] d1, input logic [7:0] idx);
    int i, a0, a1, c0, c1;
    i = 32'(idx[7:1]);
    a0 = 32'(d2[11:0]);
    a1 = 32'(d1[11:0]);
    readin = 1'b1; load_b = ld; din_2 = d2; din_1 = d1; in_index = idx;
    if (ld) begin
      bm0[i] = a0;
      bm1[i] = a1;
    end else begin
      c0 = (a0 * bm0[i] + ((a1 * bm1[i]) % Q) * gamma(i)) % Q;
      c1 = (a0 * bm1[i] + a1 * bm0[i]) % Q;
      sb.push_back('{c0, c1, i * 2, cyc + 5});
    end
    step();
    readin = 1'b0; load_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_set();
    set = 1'b1;
    step();
    set = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (set_q) pass_cnt = 0;
    if (reset) begin
      sb.delete();
      pass_cnt = 0;
      last_c0 = 0; last_c1 = 0; last_idx = 0;
    end
    if (sb.size() > 0 && sb[0].t == cyc) chk("valid_on_time", 32'(dout_valid), 1);
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(dout_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.t);
        chk("dout_2", 32'(dout_2), e.c0);
        chk("dout_1", 32'(dout_1), e.c1);
        chk("out_index", 32'(out_index), e.idx);
        last_c0 = e.c0; last_c1 = e.c1; last_idx = e.idx;
        pass_cnt++;
      end
    end else begin
      chk("hold_dout_2", 32'(dout_2), last_c0);
      chk("hold_dout_1", 32'(dout_1), last_c1);
      chk("hold_out_index", 32'(out_index), last_idx);
    end
    chk("done", 32'(done), (pass_cnt >= 128) ? 1 : 0);
  end

  initial begin
    reset = 1'b1; set = 1'b0; load_b = 1'b0; readin = 1'b0;
    din_1 = '0; din_2 = '0; in_index = '0;
    idle(2);
    reset = 1'b0;
    idle(1);

    for (int i = 0; i < 128; i++) send(1'b1, 16'd1, 16'd1, 8'(2 * i));
    send(1'b0, 16'd1, 16'd1, 8'd0);          // 18, 2
    idle(3);
    send(1'b0, 16'd1, 16'd1, 8'd2);          // 3313, 2
    send(1'b0, 16'hF001, 16'hA001, 8'd3);    // upper bits and index bit 0 ignored
    send(1'b1, 16'd3328, 16'd3328, 8'd0);
    send(1'b0, 16'd3328, 16'd3328, 8'd0);    // 18, 2 at the top of the range
    send(1'b0, 16'd4095, 16'd4095, 8'd0);
    send(1'b0, 16'd5, 16'd7, 8'd10);
    send(1'b1, 16'd100, 16'd200, 8'd10);     // reload behind an in-flight multiply
    send(1'b0, 16'd5, 16'd7, 8'd10);
    idle(8);

    pulse_set();
    for (int i = 0; i < 128; i++) send(1'b1, 16'($urandom), 16'($urandom), 8'(2 * i));
    for (int i = 0; i < 128; i++)
      send(1'b0, 16'($urandom), 16'($urandom), 8'(2 * i + $urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 16'($urandom), 8'($urandom));
    idle(8);
    pulse_set();
    idle(2);

    for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 16'($urandom), 8'(2 * i));
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) send(1'b0, 16'($urandom), 16'($urandom), 8'(40 * i));
    idle(8);

    pulse_set();
    for (int i = 0; i < 128; i++)
      send(1'b0, 16'($urandom), 16'($urandom), 8'(254 - 2 * i));
    for (int i = 0; i < 20; i++) if (sb.size() > 0) step();
    idle(2);
    chk("drain_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
